// File: rtl/riscv_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_fetch_pkg
//  Brief    : Shared types and constants for the instruction-fetch front end.
//  Revision : 1.0 - initial release
// ============================================================================
package riscv_fetch_pkg;

    // Native register/instruction width; slot fields are sized to this.
    localparam int c_XLEN = 32;

    // Default PC increment per fetched instruction.
    localparam int c_PC_STEP = 4;

    // Canonical NOP (addi x0, x0, 0) for downstream flush muxes.
    localparam logic [31:0] c_NOP_INSTR = 32'h0000_0013;

    // One queue entry: the PC it was fetched from, the returned word and
    // whether the memory has answered yet.
    typedef struct packed {
        logic [c_XLEN-1:0] pc;
        logic [c_XLEN-1:0] instr;
        logic              filled;
    } fetch_slot_t;

endpackage
`default_nettype wire

// File: rtl/fetch_slot_queue.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_slot_queue
//  Brief    : Circular slot array holding in-order fetch reservations. A slot
//             is reserved at request grant, filled by the response and popped
//             by decode. Reserved-but-unfilled slots are reported so that the
//             fetch unit knows how many responses to discard on a flush.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_slot_queue
    import riscv_fetch_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         reserve,
    input  logic [ADDR_WIDTH-1:0]        reservePc,
    input  logic                         fill,
    input  logic [DATA_WIDTH-1:0]        fillInstr,
    input  logic                         pop,
    output logic                         headValid,
    output logic [DATA_WIDTH-1:0]        headInstr,
    output logic [ADDR_WIDTH-1:0]        headPc,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [$clog2(DEPTH+1)-1:0]   pending
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH+1);

    fetch_slot_t            r_slots [DEPTH];
    logic [c_PTR_W-1:0]     r_allocPtr;
    logic [c_PTR_W-1:0]     r_fillPtr;
    logic [c_PTR_W-1:0]     r_headPtr;
    logic [c_CNT_W-1:0]     r_count;
    logic [c_CNT_W-1:0]     r_pending;
    logic [c_CNT_W-1:0]     w_countNext;
    logic [c_CNT_W-1:0]     w_pendingNext;
    logic                   w_pop;
    logic                   w_reserve;
    logic                   w_fill;

    // A flush overrides every other queue operation in the same cycle.
    assign w_reserve = reserve && !clear;
    assign w_fill    = fill    && !clear;
    assign w_pop     = pop     && !clear;

    // Net occupancy and outstanding-response changes for this cycle.
    always_comb begin
        w_countNext   = r_count;
        w_pendingNext = r_pending;
        if (w_reserve && !w_pop) begin
            w_countNext = r_count + c_CNT_W'(1);
        end else if (!w_reserve && w_pop) begin
            w_countNext = r_count - c_CNT_W'(1);
        end
        if (w_reserve && !w_fill) begin
            w_pendingNext = r_pending + c_CNT_W'(1);
        end else if (!w_reserve && w_fill) begin
            w_pendingNext = r_pending - c_CNT_W'(1);
        end
    end

    // Pointer and counter registers; wrap is natural since DEPTH is 2^n.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_allocPtr <= '0;
            r_fillPtr  <= '0;
            r_headPtr  <= '0;
            r_count    <= '0;
            r_pending  <= '0;
        end else if (clear) begin
            r_allocPtr <= '0;
            r_fillPtr  <= '0;
            r_headPtr  <= '0;
            r_count    <= '0;
            r_pending  <= '0;
        end else begin
            if (w_reserve) r_allocPtr <= r_allocPtr + c_PTR_W'(1);
            if (w_fill)    r_fillPtr  <= r_fillPtr  + c_PTR_W'(1);
            if (w_pop)     r_headPtr  <= r_headPtr  + c_PTR_W'(1);
            r_count   <= w_countNext;
            r_pending <= w_pendingNext;
        end
    end

    // Slot storage: reserve records the PC, fill lands the instruction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_slots[i] <= '0;
            end
        end else if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_slots[i].filled <= 1'b0;
            end
        end else begin
            if (w_reserve) begin
                r_slots[r_allocPtr].pc     <= c_XLEN'(reservePc);
                r_slots[r_allocPtr].filled <= 1'b0;
            end
            if (w_fill) begin
                r_slots[r_fillPtr].instr  <= c_XLEN'(fillInstr);
                r_slots[r_fillPtr].filled <= 1'b1;
            end
        end
    end

    assign headValid = (r_count != '0) && r_slots[r_headPtr].filled;
    assign headInstr = r_slots[r_headPtr].instr[DATA_WIDTH-1:0];
    assign headPc    = r_slots[r_headPtr].pc[ADDR_WIDTH-1:0];
    assign count     = r_count;
    assign pending   = r_pending;

endmodule
`default_nettype wire

// File: rtl/riscv_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_fetch_unit
//  Brief    : Decoupled instruction-fetch engine. Issues pipelined requests to
//             a request/grant instruction memory, queues responses with their
//             PCs and hands them to decode with valid/ready. Redirects flush
//             the queue and discard responses still in flight.
//  Revision : 1.0 - initial release
// ============================================================================
module riscv_fetch_unit
    import riscv_fetch_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h0,
    parameter int                    PC_STEP    = c_PC_STEP
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_gnt,
    input  logic                  imem_rvalid,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  f_valid,
    output logic [DATA_WIDTH-1:0] f_instr,
    output logic [ADDR_WIDTH-1:0] f_pc,
    input  logic                  f_ready
);

    localparam int c_CNT_W = $clog2(DEPTH+1);

    logic [ADDR_WIDTH-1:0]  r_fetchPc;
    logic [c_CNT_W-1:0]     r_dropCnt;
    logic [c_CNT_W-1:0]     w_count;
    logic [c_CNT_W-1:0]     w_pending;
    logic [c_CNT_W:0]       w_occupancy;
    logic [c_CNT_W:0]       w_dropSum;
    logic [c_CNT_W-1:0]     w_dropNext;
    logic                   w_reserve;
    logic                   w_fill;
    logic                   w_pop;
    logic                   w_unusedPcBits;

    // Target alignment bits are architecturally ignored.
    assign w_unusedPcBits = ^redirect_pc[1:0];

    // Slots reserved plus stale responses still owed bound the outstanding
    // requests; gating with rst keeps the request low while in reset.
    assign w_occupancy = {1'b0, w_count} + {1'b0, r_dropCnt};
    assign imem_req    = rst && !redirect && (w_occupancy < (c_CNT_W+1)'(DEPTH));
    assign imem_addr   = r_fetchPc;
    assign w_reserve   = imem_req && imem_gnt;

    // A live response is one not owed to a flushed request; a response with
    // nothing outstanding at all is ignored.
    assign w_fill = imem_rvalid && !redirect && (r_dropCnt == '0) && (w_pending != '0);
    assign w_pop  = f_valid && f_ready && !redirect;

    // Discard bookkeeping: a flush converts unfilled slots into debts, and
    // a response arriving in the flush cycle pays one of them off.
    assign w_dropSum = {1'b0, r_dropCnt} + {1'b0, w_pending};
    always_comb begin
        w_dropNext = r_dropCnt;
        if (redirect) begin
            if (imem_rvalid && (w_dropSum != '0)) begin
                w_dropNext = c_CNT_W'(w_dropSum - (c_CNT_W+1)'(1));
            end else begin
                w_dropNext = c_CNT_W'(w_dropSum);
            end
        end else if (imem_rvalid && (r_dropCnt != '0)) begin
            w_dropNext = r_dropCnt - c_CNT_W'(1);
        end
    end

    // Fetch PC and discard counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetchPc <= {RESET_PC[ADDR_WIDTH-1:2], 2'b00};
            r_dropCnt <= '0;
        end else begin
            r_dropCnt <= w_dropNext;
            if (redirect) begin
                r_fetchPc <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
            end else if (w_reserve) begin
                r_fetchPc <= r_fetchPc + ADDR_WIDTH'(PC_STEP);
            end
        end
    end

    fetch_slot_queue #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .clear     (redirect),
        .reserve   (w_reserve),
        .reservePc (r_fetchPc),
        .fill      (w_fill),
        .fillInstr (imem_rdata),
        .pop       (w_pop),
        .headValid (f_valid),
        .headInstr (f_instr),
        .headPc    (f_pc),
        .count     (w_count),
        .pending   (w_pending)
    );

    // A response with no request outstanding is a memory protocol error.
    a_noSpuriousRvalid: assert property (@(posedge clk) disable iff (!rst)
        imem_rvalid |-> ((r_dropCnt != '0) || (w_pending != '0)));

endmodule
`default_nettype wire

// File: tb/tb_riscv_fetch_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_riscv_fetch_unit
//  Brief    : Randomised bench for riscv_fetch_unit with an in-order,
//             variable-latency memory model and an epoch-based reference of
//             the expected instruction stream.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_fetch_unit;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt    = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata  = '0;
    logic        redirect    = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        f_valid;
    logic [31:0] f_instr;
    logic [31:0] f_pc;
    logic        f_ready     = 1'b0;

    always #5 clk = ~clk;

    riscv_fetch_unit #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .DEPTH      (DEPTH),
        .RESET_PC   (RESET_PC),
        .PC_STEP    (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .f_valid     (f_valid),
        .f_instr     (f_instr),
        .f_pc        (f_pc),
        .f_ready     (f_ready)
    );

    int checks   = 0;
    int failures = 0;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory contents: a fixed scramble of the address.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
    endfunction

    typedef struct {
        logic [31:0] addr;
        int          readyAt;
        int          epoch;
    } memReq_t;

    memReq_t     memQ[$];
    int          cycleNo = 0;
    int          epoch;
    int          liveGranted;   // granted since last flush, not yet consumed
    int          arrived;       // answered since last flush, not yet consumed
    int          pops = 0;
    logic [31:0] expPc;
    logic [31:0] nextFetch;

    int          gntPct   = 100;
    int          minLat   = 1;
    int          maxLat   = 1;
    int          readyPct = 100;
    int          redirPct = 0;
    bit          forceRedirect = 1'b0;
    logic [31:0] forceTarget   = '0;
    bit          redirOnRvalid = 1'b0;

    task automatic resetModel();
        memQ.delete();
        epoch       = 0;
        liveGranted = 0;
        arrived     = 0;
        expPc       = RESET_PC;
        nextFetch   = RESET_PC;
    endtask

    task automatic oneCycle();
        memReq_t     head;
        memReq_t     req;
        int          stale;
        int          delivEpoch;
        bit          delivering;
        bit          expReq;
        logic [31:0] tgt;
        @(negedge clk);
        cycleNo++;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        delivering  = 1'b0;
        delivEpoch  = 0;
        if (memQ.size() > 0 && memQ[0].readyAt <= cycleNo) begin
            head        = memQ.pop_front();
            imem_rvalid = 1'b1;
            imem_rdata  = memWord(head.addr);
            delivering  = 1'b1;
            delivEpoch  = head.epoch;
        end
        imem_gnt = (int'($urandom_range(99)) < gntPct);
        f_ready  = (int'($urandom_range(99)) < readyPct);
        redirect = 1'b0;
        tgt      = $urandom;
        if (forceRedirect || (redirOnRvalid && imem_rvalid) || (int'($urandom_range(99)) < redirPct)) begin
            if (forceRedirect) tgt = forceTarget;
            redirect      = 1'b1;
            redirect_pc   = tgt;
            forceRedirect = 1'b0;
            redirOnRvalid = 1'b0;
        end
        #1;
        // Outstanding = live reservations plus responses owed to old epochs.
        stale = 0;
        foreach (memQ[i]) if (memQ[i].epoch != epoch) stale++;
        if (delivering && delivEpoch != epoch) stale++;
        expReq = !redirect && ((liveGranted + stale) < DEPTH);
        checkVal("imem_req", {31'b0, imem_req}, {31'b0, expReq});
        if (imem_req) checkVal("imem_addr", imem_addr, nextFetch);
        checkVal("f_valid", {31'b0, f_valid}, {31'b0, (arrived > 0)});
        if (f_valid && f_ready && !redirect) begin
            checkVal("f_pc", f_pc, expPc);
            checkVal("f_instr", f_instr, memWord(expPc));
            expPc = expPc + 32'd4;
            pops++;
            if (liveGranted > 0) liveGranted--;
            if (arrived > 0) arrived--;
        end
        if (imem_req && imem_gnt) begin
            req.addr    = imem_addr;
            req.readyAt = cycleNo + int'($urandom_range(maxLat, minLat));
            req.epoch   = epoch;
            memQ.push_back(req);
            liveGranted++;
            nextFetch = nextFetch + 32'd4;
        end
        if (delivering && delivEpoch == epoch && !redirect) arrived++;
        if (redirect) begin
            epoch++;
            liveGranted = 0;
            arrived     = 0;
            expPc       = {redirect_pc[31:2], 2'b00};
            nextFetch   = {redirect_pc[31:2], 2'b00};
        end
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) oneCycle();
    endtask

    task automatic applyReset();
        @(posedge clk);
        #2;
        rst         = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        redirect    = 1'b0;
        f_ready     = 1'b0;
        #1;
        checkVal("reset_req",    {31'b0, imem_req}, 32'd0);
        checkVal("reset_fvalid", {31'b0, f_valid},  32'd0);
        checkVal("reset_finstr", f_instr, 32'd0);
        checkVal("reset_fpc",    f_pc,    32'd0);
        resetModel();
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
    endtask

    logic [31:0] heldAddr;
    int          popsBefore;

    initial begin
        resetModel();
        applyReset();

        // Back-to-back fetch, single-cycle memory, decode always ready.
        popsBefore = pops;
        runCycles(20);
        checkVal("throughput", 32'(pops - popsBefore), 32'd18);

        // Decode stall fills the queue, then release.
        readyPct = 0;
        runCycles(10);
        checkVal("stall_req", {31'b0, imem_req}, 32'd0);
        readyPct = 100;
        runCycles(10);

        // Three-cycle memory, flush to 0x100 with requests in flight.
        minLat = 3; maxLat = 3;
        runCycles(8);
        forceRedirect = 1'b1; forceTarget = 32'h100;
        runCycles(12);

        // Flush coinciding with a response.
        minLat = 2; maxLat = 2;
        redirOnRvalid = 1'b1;
        runCycles(10);

        // Unaligned target is aligned down.
        minLat = 1; maxLat = 1;
        forceRedirect = 1'b1; forceTarget = 32'h203;
        oneCycle();
        @(posedge clk);
        #1;
        checkVal("redirect_align", imem_addr, 32'h200);
        runCycles(8);

        // Grant withheld: address holds, queue drains.
        gntPct = 0;
        oneCycle();
        heldAddr = imem_addr;
        runCycles(5);
        checkVal("gnt_low_addr", imem_addr, heldAddr);
        checkVal("gnt_low_drained", {31'b0, f_valid}, 32'd0);
        gntPct = 100;
        runCycles(6);

        // Random traffic.
        gntPct = 70; minLat = 1; maxLat = 4; readyPct = 75; redirPct = 4;
        runCycles(1500);

        // Reset in the middle of traffic, then more random traffic.
        applyReset();
        runCycles(300);

        checkVal("progress", {31'b0, (pops > 600)}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
